// File: rtl/mem_stage_ws.sv
// MEM-stage data memory with byte/word access, sign/zero-extended byte loads,
// byte-lane stores and a configurable number of wait states. The pipeline is
// held via a combinational stall while an access waits for completion.
module mem_stage_ws #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              misalign_err
);

  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                byte_q, byte_d;
  logic                sext_q, sext_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Operands come straight from the pipeline in IDLE, from the latch in BUSY.
  logic                busy;
  logic                op_we, op_byte, op_sext;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic [IDX_W-1:0]    op_idx;
  logic [LB-1:0]       op_lane;
  logic                complete;
  logic                misaligned;
  logic [DATA_W-1:0]   rd_word;
  logic [7:0]          rd_byte;
  logic [DATA_W-1:0]   rd_ext;
  logic [DATA_W-1:0]   wr_word;
  logic                wr_en;

  assign busy     = (state_q == BUSY);
  assign op_we    = busy ? we_q    : req_we;
  assign op_byte  = busy ? byte_q  : req_byte;
  assign op_sext  = busy ? sext_q  : req_sext;
  assign op_addr  = busy ? addr_q  : addr;
  assign op_wdata = busy ? wdata_q : wdata;

  // Truncating the word address to IDX_W bits makes high address bits alias.
  assign op_idx     = IDX_W'(op_addr >> LB);
  assign op_lane    = op_addr[LB-1:0];
  assign complete   = busy ? (cnt_q == 4'd0) : (req_valid && (WAIT_CYCLES == 0));
  assign misaligned = !op_byte && (op_lane != '0);

  assign rd_word = mem_q[op_idx];
  assign rd_byte = 8'(rd_word >> {op_lane, 3'b000});
  assign rd_ext  = op_sext ? {{(DATA_W-8){rd_byte[7]}}, rd_byte}
                           : {{(DATA_W-8){1'b0}}, rd_byte};

  // Store data merge: a byte store replaces one lane and keeps the rest.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign wr_word[8*gi +: 8] = !op_byte              ? op_wdata[8*gi +: 8] :
                                (op_lane == LB'(gi))  ? op_wdata[7:0]       :
                                                        rd_word[8*gi +: 8];
  end

  // Output decode; reset forces every output low immediately.
  always_comb begin
    stall        = 1'b0;
    rdata        = '0;
    rdata_valid  = 1'b0;
    misalign_err = 1'b0;
    wr_en        = 1'b0;
    if (!rst) begin
      stall = busy ? (cnt_q != 4'd0) : (req_valid && (WAIT_CYCLES != 0));
      if (complete) begin
        misalign_err = misaligned;
        if (op_we) begin
          wr_en = !misaligned;
        end else begin
          rdata_valid = 1'b1;
          if (!misaligned) rdata = op_byte ? rd_ext : rd_word;
        end
      end
    end
  end

  // Next-state logic: accept into BUSY, count down, return to IDLE on completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    byte_d  = byte_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && (WAIT_CYCLES != 0)) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          we_d    = req_we;
          byte_d  = req_byte;
          sext_d  = req_sext;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and latched-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage array: cleared on reset, one word written per completing store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[op_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: three instances (16-bit/0 waits, 16-bit/2 waits,
// 32-bit/3 waits) run the same directed sequence against a per-instance
// word-array model; every cycle the outputs are compared to the model.
module tb_mem_stage_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int DW    = (gi == 2) ? 32 : 16;
    localparam int WC    = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
    localparam int LANES = DW / 8;

    logic          rst, rv, we, by, sx;
    logic [15:0]   a;
    logic [DW-1:0] wd;
    logic          st, rdv, me;
    logic [DW-1:0] rd;
    logic          done_r = 1'b0;

    logic          e_st, e_rv, e_me;
    logic [DW-1:0] e_rd;
    logic [DW-1:0] mdl [256];
    logic [DW-1:0] r;

    mem_stage_ws #(.DATA_W(DW), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst), .req_valid(rv), .req_we(we), .req_byte(by),
      .req_sext(sx), .addr(a), .wdata(wd), .stall(st), .rdata(rd),
      .rdata_valid(rdv), .misalign_err(me)
    );

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
      chk($sformatf("c%0d stall", gi), 64'(st), 64'(e_st));
      chk($sformatf("c%0d rdata", gi), 64'(rd), 64'(e_rd));
      chk($sformatf("c%0d rdata_valid", gi), 64'(rdv), 64'(e_rv));
      chk($sformatf("c%0d misalign_err", gi), 64'(me), 64'(e_me));
    end

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk); #1;
        rv = 1'b0; we = 1'($urandom); by = 1'($urandom); sx = 1'($urandom);
        a = 16'($urandom); wd = DW'($urandom);
        e_st = 1'b0; e_rv = 1'b0; e_me = 1'b0; e_rd = '0;
      end
    endtask

    // One access: predicts outputs for WC+1 cycles, then applies a store.
    task automatic op(input logic w, input logic b, input logic s,
                      input logic [15:0] ad, input logic [DW-1:0] d,
                      output logic [DW-1:0] res);
      int idx, lane;
      logic mis;
      logic [7:0] bt;
      idx  = (int'(ad) / LANES) % 256;
      lane = int'(ad) % LANES;
      mis  = !b && (lane != 0);
      bt   = 8'(mdl[idx] >> (8 * lane));
      res  = '0;
      if (!w && !mis) begin
        if (!b)                   res = mdl[idx];
        else if (s && bt >= 128)  res = DW'(bt) - DW'(256);
        else                      res = DW'(bt);
      end
      for (int k = 0; k <= WC; k++) begin
        @(posedge clk); #1;
        if (k == 0) begin
          rv = 1'b1; we = w; by = b; sx = s; a = ad; wd = d;
        end else begin
          rv = 1'($urandom); we = 1'($urandom); by = 1'($urandom);
          sx = 1'($urandom); a = 16'($urandom); wd = DW'($urandom);
        end
        e_st = (k < WC);
        e_rv = (k == WC) && !w;
        e_me = (k == WC) && mis;
        e_rd = (k == WC) ? res : '0;
      end
      if (w && !mis) begin
        if (b) mdl[idx] = (mdl[idx] & ~(DW'(255) << (8 * lane))) | (DW'(d[7:0]) << (8 * lane));
        else   mdl[idx] = d;
      end
    endtask

    initial begin
      for (int i = 0; i < 256; i++) mdl[i] = '0;
      rst = 1'b1; rv = 1'b1; we = 1'b0; by = 1'b0; sx = 1'b0; a = 16'h0004; wd = '0;
      e_st = 1'b0; e_rv = 1'b0; e_me = 1'b0; e_rd = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; rv = 1'b0;
      idle(1);

      op(1'b1, 1'b0, 1'b0, 16'h0004, DW'(32'hBEEF), r);
      op(1'b0, 1'b0, 1'b0, 16'h0004, '0, r);
      chk($sformatf("c%0d pin word load", gi), 64'(r), 64'hBEEF);
      idle(2);

      op(1'b1, 1'b1, 1'b0, 16'h0005, DW'(32'h1280), r);
      op(1'b0, 1'b0, 1'b0, 16'h0004, '0, r);
      chk($sformatf("c%0d pin byte merge", gi), 64'(r), 64'h80EF);
      op(1'b0, 1'b1, 1'b1, 16'h0005, '0, r);
      chk($sformatf("c%0d pin sext load", gi), 64'(r[15:0]), 64'hFF80);
      op(1'b0, 1'b1, 1'b0, 16'h0005, '0, r);
      chk($sformatf("c%0d pin zext load", gi), 64'(r), 64'h0080);
      op(1'b0, 1'b1, 1'b0, 16'h0004, '0, r);
      chk($sformatf("c%0d pin lane0 load", gi), 64'(r), 64'h00EF);
      idle(1);

      op(1'b0, 1'b0, 1'b0, 16'h0003, '0, r);
      op(1'b1, 1'b0, 1'b0, 16'h0003, DW'(32'h1234), r);
      op(1'b0, 1'b0, 1'b0, 16'(3 & ~(LANES - 1)), '0, r);
      chk($sformatf("c%0d pin misaligned store dropped", gi), 64'(r), 64'h0);

      op(1'b1, 1'b0, 1'b0, 16'(256 * LANES), DW'(32'hA5A5), r);
      op(1'b0, 1'b0, 1'b0, 16'h0000, '0, r);
      chk($sformatf("c%0d pin wrap", gi), 64'(r), 64'hA5A5);

      op(1'b1, 1'b0, 1'b0, 16'h0008, DW'(32'h11223344), r);
      op(1'b1, 1'b1, 1'b0, 16'h000B, DW'(32'h7F), r);
      op(1'b0, 1'b0, 1'b0, 16'h0008, '0, r);
      chk($sformatf("c%0d pin top lane", gi), 64'(r), (DW == 32) ? 64'h7F223344 : 64'h3344);

      // Reset during the access (second stall cycle when there are waits).
      for (int k = 0; k <= ((WC > 0) ? 1 : 0); k++) begin
        @(posedge clk); #1;
        rv = 1'b1; we = 1'b1; by = 1'b0; sx = 1'b0; a = 16'h0010; wd = DW'(32'h5555);
        if (k == ((WC > 0) ? 1 : 0)) begin
          rst = 1'b1;
          e_st = 1'b0;
        end else begin
          e_st = 1'b1;
        end
        e_rv = 1'b0; e_me = 1'b0; e_rd = '0;
      end
      for (int i = 0; i < 256; i++) mdl[i] = '0;
      @(posedge clk); #1;
      rst = 1'b0; rv = 1'b0;
      op(1'b0, 1'b0, 1'b0, 16'h0010, '0, r);
      chk($sformatf("c%0d pin store abandoned", gi), 64'(r), 64'h0);
      op(1'b0, 1'b0, 1'b0, 16'h0000, '0, r);
      chk($sformatf("c%0d pin array cleared", gi), 64'(r), 64'h0);
      idle(2);
      done_r = 1'b1;
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int i = 0; i < 2000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g[0].done_r && g[1].done_r && g[2].done_r;
    end
    n_tests++;
    if (!all_done) begin
      n_fail++;
      $display("FAIL timeout: got not done expected done");
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
- Parametrised MEM-stage data memory for the 5-stage pipeline.
- Generalises the fixed 16-bit, 256-word, single-cycle memory in three ways:
  - configurable data width and depth;
  - byte/word access with sign/zero extension and byte-lane stores;
  - configurable wait states, with a stall handshake back to the pipeline.
- With WAIT_CYCLES=0 and full-word accesses it behaves as the current single-cycle MEM stage.

Parameters:
DATA_W, 16, data word width in bits; multiple of 8, ≥16; LANES=DATA_W/8, LB=log2(LANES).
ADDR_W, 16, byte address width.
DEPTH, 256, number of words; power of two.
WAIT_CYCLES, 0, extra cycles per access (0..15); pipeline is stalled this many cycles.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  MEM-stage instruction is a load or store this cycle.
req_we  in  1  1 = store, 0 = load.
req_byte  in  1  1 = byte access, 0 = full-word access.
req_sext  in  1  loads only: 1 = sign-extend byte, 0 = zero-extend.
addr  in  ADDR_W  byte address.
wdata  in  DATA_W  store data; byte stores use wdata[7:0].
stall  out  1  hold IF/ID/EX/MEM; combinational.
rdata  out  DATA_W  load result; valid while rdata_valid=1.
rdata_valid  out  1  completion cycle of a load.
misalign_err  out  1  completion cycle of a misaligned word access.

Behaviour:
- Storage:
  - DEPTH x DATA_W array.
  - Word index = addr[ADDR_W-1:LB] mod DEPTH, so high bits alias (wrap).
  - Lane = addr[LB-1:0], little-endian (lane 0 = bits 7:0).
- Reset (async):
  - Whole array cleared to 0.
  - FSM to IDLE; counter to 0; latched request cleared.
  - Outputs: stall=0, rdata=0, rdata_valid=0, misalign_err=0.
  - A pending store is discarded.
- FSM states IDLE, BUSY; down-counter cnt, 4 bits.
- IDLE, req_valid=0: all outputs 0 (rdata=0).
- IDLE, req_valid=1, WAIT_CYCLES=0:
  - This is the completion cycle; inputs are used directly.
  - stall=0.
  - A load's rdata is combinational from the array.
  - A store commits at the rising edge ending the cycle.
- IDLE, req_valid=1, WAIT_CYCLES>0:
  - Accept: latch req_we/req_byte/req_sext/addr/wdata.
  - cnt←WAIT_CYCLES-1; go to BUSY; stall=1 this cycle.
- BUSY, cnt≠0: stall=1; cnt←cnt-1. Inputs are ignored; the pipeline holds them stable regardless.
- BUSY, cnt=0: completion cycle using latched operands; stall=0; next state IDLE.
- Latency: a request presented in cycle T completes in cycle T+WAIT_CYCLES. stall is high for exactly T..T+WAIT_CYCLES-1.
- Back-to-back: the next request is presented in T+WAIT_CYCLES+1 and accepted from IDLE. No extra bubble is inserted beyond the wait states.
- Completion-cycle rules:
  - Word access with addr[LB-1:0]≠0:
    - misalign_err=1.
    - Store suppressed; load returns rdata=0 with rdata_valid=1.
  - Word load: rdata=mem[idx]; rdata_valid=1.
  - Byte load:
    - b = mem[idx][8*lane+7 : 8*lane].
    - rdata = sign- or zero-extension of b to DATA_W per req_sext.
    - rdata_valid=1.
  - Word store: mem[idx]←wdata at the edge.
  - Byte store: only lane bits ← wdata[7:0]; other lanes unchanged.
  - Stores: rdata_valid=0, rdata=0.
- Outputs other than stall are 0 in every non-completion cycle.
- Read after write:
  - A load completing in the cycle after a store completes sees the stored value.
  - No same-cycle forwarding is needed, since accesses are serialised.
- Reset asserted in BUSY: the access is abandoned, with no write and no rdata_valid. After deassert the block is in IDLE.
- req_valid deasserted while BUSY: ignored; the latched access completes.

Test Plan:
1. DATA_W=16, WAIT=0: store 0xBEEF @0x0004, then load @0x0004 next cycle → rdata=0xBEEF, rdata_valid=1 in that cycle; stall never 1.
2. WAIT=2: load @0x0004 in T (0xBEEF stored earlier) → stall=1 in T,T+1; T+2 stall=0, rdata=0xBEEF, rdata_valid=1; T+3 outputs 0.
3. Byte store 0x80 @0x0005 over 0xBEEF → word 0x80EF. Signed byte load @0x0005 → 0xFF80; unsigned → 0x0080; byte load @0x0004 unsigned → 0x00EF.
4. Word load @0x0003 → misalign_err=1, rdata=0, rdata_valid=1. Word store 0x1234 @0x0003 → misalign_err=1, memory unchanged.
5. WAIT=3: store 0x5555 @0x0010, assert rst in 2nd stall cycle → stall→0 immediately; after release, load @0x0010 returns 0x0000.
6. DEPTH=256, DATA_W=16: store 0xA5A5 @0x0200 → load @0x0000 returns 0xA5A5 (wrap). DATA_W=32 instance: byte store 0x7F @lane 3 sets bits 31:24 only.
